// File: rtl/eth_pkg.sv
// Shared types and constants for the transmit framing stage.
// Also holds the byte-wide reflected CRC-32 step that the CRC engine uses.
package eth_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_e;

  localparam int          ETH_MIN_PAYLOAD = 60;
  localparam int          ETH_FCS_BYTES   = 4;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY_REF  = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // LSB-first update of the raw CRC register by one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32.sv
// Byte-wide Ethernet CRC-32 engine; crc_clr has priority over data_in_valid.
// crc32_out is the complemented register, i.e. the FCS value ready to send LSB first.
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_clr,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  output logic [31:0] crc32_out
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (crc_clr)            crc_d = CRC32_INIT;
    else if (data_in_valid) crc_d = crc32_byte(crc_q, data_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC32_INIT;
    else        crc_q <= crc_d;
  end

  assign crc32_out = ~crc_q;

endmodule

// File: rtl/eth_fcs_append.sv
// Transmit framing: passes payload, zero-pads short frames, appends the 4-byte FCS.
// Output is a single register stage that holds while m_valid && !m_ready.
module eth_fcs_append
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = ETH_MIN_PAYLOAD,
  parameter bit          PAD_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);

  localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_adv;
  logic [1:0]  fidx_q, fidx_d;
  logic [31:0] fcs_q, fcs_d, fcs_src;
  logic [7:0]  m_data_q, m_data_d, crc_byte;
  logic        m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic        load, accept, short_frm, fcs_done, crc_clr, crc_vld;
  logic [31:0] crc32_out;

  assign load      = !m_valid_q || m_ready;
  assign s_ready   = ((state_q == IDLE) || (state_q == DATA)) && load;
  assign accept    = s_valid && s_ready;
  assign cnt_adv   = (state_q == IDLE) ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
  assign short_frm = PAD_EN && ({1'b0, cnt_adv} < MIN_LEN_W);
  assign fcs_done  = (state_q == FCS) && load && m_last_q;
  // The CRC register settles on the same edge as the final data/pad byte, so
  // FCS byte 0 is taken straight from it; the rest come from the latched copy.
  assign fcs_src   = (fidx_q == 2'd0) ? crc32_out : fcs_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = s_last ? (short_frm ? PAD : FCS) : DATA;
      DATA:    if (accept && s_last) state_d = short_frm ? PAD : FCS;
      PAD:     if (load && !short_frm) state_d = FCS;
      FCS:     if (fcs_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    cnt_d     = cnt_q;
    fidx_d    = fidx_q;
    fcs_d     = fcs_q;
    crc_vld   = 1'b0;
    crc_byte  = s_data;
    unique case (state_q)
      IDLE, DATA: begin
        if (load) begin
          m_valid_d = accept;
          m_last_d  = 1'b0;
          if (accept) begin
            m_data_d = s_data;
            cnt_d    = cnt_adv;
            crc_vld  = 1'b1;
          end
        end
      end
      PAD: begin
        if (load) begin
          m_valid_d = 1'b1;
          m_data_d  = 8'h00;
          cnt_d     = cnt_adv;
          crc_vld   = 1'b1;
          crc_byte  = 8'h00;
        end
      end
      FCS: begin
        if (fidx_q == 2'd0) fcs_d = crc32_out;
        if (load) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            cnt_d     = 16'd0;
            fidx_d    = 2'd0;
          end else begin
            m_valid_d = 1'b1;
            m_data_d  = fcs_src[8*fidx_q +: 8];
            m_last_d  = (fidx_q == 2'(ETH_FCS_BYTES - 1));
            fidx_d    = fidx_q + 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= 8'h00;
      cnt_q     <= 16'd0;
      fidx_q    <= 2'd0;
      fcs_q     <= 32'h0;
    end else begin
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      cnt_q     <= cnt_d;
      fidx_q    <= fidx_d;
      fcs_q     <= fcs_d;
    end
  end

  // Re-seed between frames, including when a new frame starts right after FCS drains.
  assign crc_clr = rst || ((state_q == IDLE) && !accept) || fcs_done;

  crc32 u_crc (
    .clk           (clk),
    .rst_n         (1'b1),
    .crc_clr       (crc_clr),
    .data_in       (crc_byte),
    .data_in_valid (crc_vld),
    .crc32_out     (crc32_out)
  );

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);

endmodule
